// File: rtl/aes_key_expand.sv
// Iterative AES-128 key expansion: latches a cipher key on start and presents
// round keys 0..10 in order, advancing one round per valid/ready handshake.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s_c
);
    localparam logic [7:0] INV_EXP = 8'hfe;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (INV_EXP[i]) r = gf_mul(r, x);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        s_c = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(10);
    localparam logic [7:0]       RCON_INIT  = 8'h01;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [7:0]       rcon, rcon_nxt;
    logic [KEY_W-1:0] rk_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             valid_nxt, busy_nxt, done_nxt;

    logic [WORD_W-1:0] w0, w1, w2, w3, rot, sub, t;
    logic [WORD_W-1:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = round_key;
    assign rot = {w3[23:0], w3[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (
                .a   (rot[8*g +: 8]),
                .s_c (sub[8*g +: 8])
            );
        end
    endgenerate

    // One-level next round key: SubWord/RotWord plus the XOR chain
    assign t  = sub ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            round_key <= '0;
            round_idx <= '0;
            rcon      <= RCON_INIT;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            round_key <= rk_nxt;
            round_idx <= idx_nxt;
            rcon      <= rcon_nxt;
            key_valid <= valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rk_nxt    = round_key;
        idx_nxt   = round_idx;
        rcon_nxt  = rcon;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = EXPAND;
                    rk_nxt    = key_in;
                    idx_nxt   = '0;
                    rcon_nxt  = RCON_INIT;
                end
            end
            EXPAND: begin
                if (key_ready) begin
                    if (round_idx == LAST_ROUND) begin
                        // last key stays on the outputs after the final handshake
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        rk_nxt   = {n0, n1, n2, n3};
                        idx_nxt  = round_idx + IDX_W'(1);
                        rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        valid_nxt = (state_nxt == EXPAND);
        busy_nxt  = (state_nxt == EXPAND);
    end
endmodule
